// File: rtl/key_scan_debounce.sv
// rtl/key_scan_debounce.sv - synchronised, debounced key inputs with press/release pulses, auto-repeat and key encoder
module key_scan_debounce #(
    parameter int N_KEYS          = 5,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CODE_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keys_raw,
    input  logic [N_KEYS-1:0] repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rep_state_t;

    logic [N_KEYS-1:0] s1;
    logic [N_KEYS-1:0] s2;
    logic [N_KEYS-1:0] toggle;
    logic [N_KEYS-1:0] rep_pulse;
    logic [CODE_W-1:0] low_code;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [DW-1:0] db_cnt;
        logic          db_toggle;
        logic          press_ev;
        logic          rel_ev;
        logic [RW-1:0] rcnt;
        rep_state_t    st;
        rep_state_t    st_next;
        logic          pulse;

        // A single agreeing sample clears the count, so glitches never accumulate.
        assign db_toggle = (s2[i] != key_level[i]) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
        assign press_ev  = db_toggle & ~key_level[i];
        assign rel_ev    = db_toggle & key_level[i];
        assign toggle[i] = db_toggle;

        always_ff @(posedge clk) begin
            if (!rst) begin
                db_cnt <= '0;
            end else if ((s2[i] == key_level[i]) || db_toggle) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                st   <= IDLE;
                rcnt <= '0;
            end else begin
                st <= st_next;
                if ((st_next != st) || (st == IDLE)) begin
                    rcnt <= '0;
                end else if ((st == RPT) && (rcnt == RW'(REPEAT_PERIOD - 1))) begin
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end
        end

        always_comb begin
            st_next = st;
            case (st)
                IDLE:    if (press_ev && repeat_en[i]) st_next = DELAY;
                DELAY: begin
                    if (rel_ev || !repeat_en[i]) begin
                        st_next = IDLE;
                    end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                        st_next = RPT;
                    end
                end
                RPT:     if (rel_ev || !repeat_en[i]) st_next = IDLE;
                default: st_next = IDLE;
            endcase
        end

        always_comb begin
            pulse = 1'b0;
            if ((st == DELAY) && (st_next == RPT)) begin
                pulse = 1'b1;
            end else if ((st == RPT) && (st_next == RPT) && (rcnt == RW'(REPEAT_PERIOD - 1))) begin
                pulse = 1'b1;
            end
        end

        assign rep_pulse[i] = pulse;
    end

    always_comb begin
        low_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (key_press[i]) low_code = CODE_W'(i);
        end
    end

    // Press and release are registered on the same edge that flips key_level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1          <= '0;
            s2          <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
        end else begin
            s1          <= keys_raw;
            s2          <= s1;
            key_level   <= key_level ^ toggle;
            key_press   <= (toggle & ~key_level) | rep_pulse;
            key_release <= toggle & key_level;
            key_valid   <= |key_press;
            if (|key_press) key_code <= low_code;
        end
    end

endmodule

// File: tb/tb_key_scan_debounce.sv
// tb/tb_key_scan_debounce.sv - randomized and directed bench for key_scan_debounce against a timestamp-based model
module tb_key_scan_debounce;

    localparam int NK  = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int CW  = 4;

    logic          clk;
    logic          rst;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          key_valid;
    logic [CW-1:0] key_code;

    key_scan_debounce #(
        .N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP), .CODE_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .keys_raw(keys_raw), .repeat_en(repeat_en),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_valid(key_valid), .key_code(key_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return CW'(i);
        return '0;
    endfunction

    // Reference: a level change is accepted once the synchronised input has
    // disagreed for DEB consecutive edges; repeats fall at press+RD+k*RP.
    logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_release = '0;
    logic          m_valid = 1'b0;
    logic [CW-1:0] m_code = '0;
    int            edge_n = 0;
    int            diff_since [NK];
    int            press_t [NK];
    bit            armed [NK];

    always @(posedge clk) begin
        logic [NK-1:0] tog;
        logic [NK-1:0] rep;
        edge_n++;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
            m_valid = 1'b0; m_code = '0;
            for (int i = 0; i < NK; i++) begin
                diff_since[i] = -1; press_t[i] = 0; armed[i] = 1'b0;
            end
        end else begin
            tog = '0;
            rep = '0;
            for (int i = 0; i < NK; i++) begin
                if (m_s2[i] != m_level[i]) begin
                    if (diff_since[i] < 0) diff_since[i] = edge_n;
                    if (edge_n - diff_since[i] == DEB - 1) begin
                        tog[i] = 1'b1;
                        diff_since[i] = -1;
                    end
                end else begin
                    diff_since[i] = -1;
                end
                if (tog[i] && m_level[i]) armed[i] = 1'b0;
                else if (!repeat_en[i]) armed[i] = 1'b0;
                else if (armed[i] && (edge_n - press_t[i] >= RD) &&
                         ((edge_n - press_t[i] - RD) % RP == 0)) rep[i] = 1'b1;
                if (tog[i] && !m_level[i]) begin
                    armed[i] = repeat_en[i];
                    press_t[i] = edge_n;
                end
            end
            m_valid = |m_press;
            if (|m_press) m_code = lowest(m_press);
            m_press   = (tog & ~m_level) | rep;
            m_release = tog & m_level;
            m_level   = m_level ^ tog;
            m_s2      = m_s1;
            m_s1      = keys_raw;
        end
    end

    int press_cnt [NK];
    int rel_cnt [NK];

    initial for (int i = 0; i < NK; i++) begin
        press_cnt[i] = 0;
        rel_cnt[i] = 0;
    end

    always @(posedge clk) begin
        #2;
        chk("m_level", 32'(key_level), 32'(m_level));
        chk("m_press", 32'(key_press), 32'(m_press));
        chk("m_release", 32'(key_release), 32'(m_release));
        chk("m_valid", 32'(key_valid), 32'(m_valid));
        chk("m_code", 32'(key_code), 32'(m_code));
        for (int i = 0; i < NK; i++) begin
            if (key_press[i]) press_cnt[i]++;
            if (key_release[i]) rel_cnt[i]++;
        end
    end

    initial begin
        int  bp;
        int  br;
        bit  seen;
        rst = 1'b0;
        keys_raw = '1;
        repeat_en = '0;

        // Reset with all keys held, then the held keys debounce in.
        repeat (3) begin
            @(negedge clk);
            chk("rst_level", 32'(key_level), 0);
            chk("rst_press", 32'(key_press), 0);
            chk("rst_valid", 32'(key_valid), 0);
            chk("rst_code", 32'(key_code), 0);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t1_level_e5", 32'(key_level), 0);
        @(negedge clk);
        chk("t1_level_e6", 32'(key_level), 32'h1f);
        chk("t1_press", 32'(key_press), 32'h1f);
        @(negedge clk);
        chk("t1_press_off", 32'(key_press), 0);
        chk("t1_valid", 32'(key_valid), 1);
        chk("t1_code", 32'(key_code), 0);
        keys_raw = '0;
        repeat (12) @(negedge clk);

        // Glitch rejection on key 2.
        bp = press_cnt[2];
        keys_raw[2] = 1'b1;
        repeat (3) @(negedge clk);
        keys_raw[2] = 1'b0;
        @(negedge clk);
        keys_raw[2] = 1'b1;
        repeat (5) @(negedge clk);
        chk("t2_level_e5", 32'(key_level[2]), 0);
        @(negedge clk);
        chk("t2_level_e6", 32'(key_level[2]), 1);
        chk("t2_press", 32'(key_press), 32'h04);
        @(negedge clk);
        chk("t2_valid", 32'(key_valid), 1);
        chk("t2_code", 32'(key_code), 2);
        repeat (3) @(negedge clk);
        keys_raw[2] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t2_npress", 32'(press_cnt[2] - bp), 1);

        // Auto-repeat on key 1, held 40 cycles.
        bp = press_cnt[1];
        br = rel_cnt[1];
        repeat_en[1] = 1'b1;
        keys_raw[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_press0", 32'(key_press[1]), 1);
        repeat (9) @(negedge clk);
        chk("t3_gap", 32'(key_press[1]), 0);
        @(negedge clk);
        chk("t3_rep1", 32'(key_press[1]), 1);
        repeat (24) @(negedge clk);
        keys_raw[1] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t3_npress", 32'(press_cnt[1] - bp), 7);
        chk("t3_nrel", 32'(rel_cnt[1] - br), 1);
        repeat_en[1] = 1'b0;

        // Repeat disabled at press, enabled mid-hold on key 3.
        bp = press_cnt[3];
        keys_raw[3] = 1'b1;
        repeat (20) @(negedge clk);
        repeat_en[3] = 1'b1;
        repeat (20) @(negedge clk);
        keys_raw[3] = 1'b0;
        repeat (12) @(negedge clk);
        chk("t4_npress", 32'(press_cnt[3] - bp), 1);
        repeat_en[3] = 1'b0;

        // Simultaneous press of keys 4 and 1.
        keys_raw = 5'b10010;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (key_press != '0) seen = 1'b1;
        end
        if (!seen) chk("t5_timeout", 0, 1);
        chk("t5_press", 32'(key_press), 32'h12);
        @(negedge clk);
        chk("t5_valid", 32'(key_valid), 1);
        chk("t5_code", 32'(key_code), 1);
        keys_raw = '0;
        repeat (12) @(negedge clk);

        // Reset while key 0 is repeating and still held.
        repeat_en[0] = 1'b1;
        keys_raw[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_press0", 32'(key_press[0]), 1);
        repeat (17) @(negedge clk);
        br = rel_cnt[0];
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_level", 32'(key_level), 0);
        chk("t6_rst_press", 32'(key_press), 0);
        chk("t6_rst_valid", 32'(key_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_press_e5", 32'(key_press[0]), 0);
        @(negedge clk);
        chk("t6_press_e6", 32'(key_press[0]), 1);
        chk("t6_norel", 32'(rel_cnt[0] - br), 0);
        keys_raw = '0;
        repeat_en = '0;
        repeat (12) @(negedge clk);

        // Random phase: alternate fast chatter and long holds.
        for (int c = 0; c < 2000; c++) begin
            int div;
            @(negedge clk);
            div = ((c / 200) % 2 == 1) ? 40 : 6;
            for (int i = 0; i < NK; i++) begin
                if ($urandom_range(0, div - 1) == 0) keys_raw[i] = ~keys_raw[i];
            end
            if ($urandom_range(0, 47) == 0) repeat_en = NK'($urandom);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst = 1'b0;
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
